// File: rtl/nco_iq_unpack_mc_pkg.sv
// ============================================================================
// Module   : nco_iq_unpack_mc_pkg
// Brief    : Shared types and width helpers for the multi-channel NCO unpacker.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package nco_iq_unpack_mc_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } skid_state_e;

    // Component width of a packed cos/sin lane.
    function automatic int comp_width(input int lane_w);
        return lane_w / 2;
    endfunction

    // Width able to hold 0..2*n_ch saturation flags.
    function automatic int flag_sum_width(input int n_ch);
        return $clog2(2 * n_ch + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/nco_iq_unpack_mc_if.sv
// ============================================================================
// Module   : nco_iq_unpack_mc_if
// Brief    : Packed-lane input stream and I/Q output stream of the unpacker.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface nco_iq_unpack_mc_if #(
    parameter int N_CH    = 2,
    parameter int LANE_W  = 32,
    parameter int O_WIDTH = 12
);
    logic [N_CH*LANE_W-1:0]  s_tdata;
    logic                    s_tvalid;
    logic                    s_tready;
    logic [N_CH*O_WIDTH-1:0] m_cos;
    logic [N_CH*O_WIDTH-1:0] m_sin;
    logic                    m_tvalid;
    logic                    m_tready;

    // slave: the unpacker itself; master: the surrounding DDS bank and mixers
    modport slave (
        input  s_tdata, s_tvalid, m_tready,
        output s_tready, m_cos, m_sin, m_tvalid
    );

    modport master (
        output s_tdata, s_tvalid, m_tready,
        input  s_tready, m_cos, m_sin, m_tvalid
    );
endinterface

`default_nettype wire

// File: rtl/nco_iq_unpack_mc_round_sat.sv
// ============================================================================
// Module   : nco_iq_unpack_mc_round_sat
// Brief    : One component: round-half-up to O_WIDTH, clip, optional negate.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module nco_iq_unpack_mc_round_sat #(
    parameter int C_W     = 16,
    parameter int O_WIDTH = 12
) (
    input  wire logic [C_W-1:0]     x_i,
    input  wire logic               neg_i,
    output logic      [O_WIDTH-1:0] y_o,
    output logic                    sat_o
);
    localparam logic [O_WIDTH-1:0] C_MAX = {1'b0, {(O_WIDTH-1){1'b1}}};
    localparam logic [O_WIDTH-1:0] C_MIN = {1'b1, {(O_WIDTH-1){1'b0}}};

    logic [O_WIDTH-1:0] w_rnd;
    logic               w_rnd_sat;

    generate
        if (C_W == O_WIDTH) begin : g_pass
            assign w_rnd     = x_i;
            assign w_rnd_sat = 1'b0;
        end else begin : g_round
            localparam int             SH    = C_W - O_WIDTH;
            localparam logic [C_W:0]   C_OFS = (C_W+1)'(1) << (SH - 1);

            logic [C_W:0]     w_sum;
            logic [O_WIDTH:0] w_shr;
            logic             w_unused_lsb;

            assign w_sum        = {x_i[C_W-1], x_i} + C_OFS;
            assign w_shr        = w_sum[C_W:SH];
            assign w_unused_lsb = ^w_sum[SH-1:0];
            // Rounding can only overflow upward, so a sign mismatch means > max.
            assign w_rnd_sat    = w_shr[O_WIDTH] ^ w_shr[O_WIDTH-1];
            assign w_rnd        = w_rnd_sat ? C_MAX : w_shr[O_WIDTH-1:0];
        end
    endgenerate

    always_comb begin
        y_o   = w_rnd;
        sat_o = w_rnd_sat;
        if (neg_i) begin
            if (w_rnd == C_MIN) begin
                y_o   = C_MAX;
                sat_o = 1'b1;
            end else begin
                y_o = -w_rnd;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/nco_iq_unpack_mc.sv
// ============================================================================
// Module   : nco_iq_unpack_mc
// Brief    : N-lane DDS cos/sin unpacker with rounding, conj/swap and skid output.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module nco_iq_unpack_mc
    import nco_iq_unpack_mc_pkg::*;
#(
    parameter int N_CH    = 2,
    parameter int LANE_W  = 32,
    parameter int O_WIDTH = 12,
    parameter int CNT_W   = 16
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    nco_iq_unpack_mc_if.slave     bus,
    input  wire logic [N_CH-1:0]  cfg_conj_i,
    input  wire logic             cfg_swap_i,
    input  wire logic             sat_clr_i,
    output logic      [CNT_W-1:0] sat_cnt_o
);
    localparam int C_W   = comp_width(LANE_W);
    localparam int SUM_W = flag_sum_width(N_CH);
    localparam int OUT_W = N_CH * O_WIDTH;

    logic [OUT_W-1:0]  w_cos, w_sin;
    logic [2*N_CH-1:0] w_sat;
    logic [SUM_W-1:0]  w_nsat;
    logic              w_acc, w_rdy;
    logic [CNT_W:0]    w_cnt_sum;

    generate
        for (genvar k = 0; k < N_CH; k++) begin : g_ch
            logic [O_WIDTH-1:0] w_c, w_s;

            nco_iq_unpack_mc_round_sat #(.C_W(C_W), .O_WIDTH(O_WIDTH)) u_cos (
                .x_i   (bus.s_tdata[k*LANE_W +: C_W]),
                .neg_i (1'b0),
                .y_o   (w_c),
                .sat_o (w_sat[2*k])
            );

            nco_iq_unpack_mc_round_sat #(.C_W(C_W), .O_WIDTH(O_WIDTH)) u_sin (
                .x_i   (bus.s_tdata[k*LANE_W+C_W +: C_W]),
                .neg_i (cfg_conj_i[k]),
                .y_o   (w_s),
                .sat_o (w_sat[2*k+1])
            );

            assign w_cos[k*O_WIDTH +: O_WIDTH] = cfg_swap_i ? w_s : w_c;
            assign w_sin[k*O_WIDTH +: O_WIDTH] = cfg_swap_i ? w_c : w_s;
        end
    endgenerate

    always_comb begin
        w_nsat = '0;
        for (int i = 0; i < 2*N_CH; i++) begin
            w_nsat = w_nsat + SUM_W'(w_sat[i]);
        end
    end

    skid_state_e      state_q, state_d;
    logic [OUT_W-1:0] main_cos_q, main_cos_d, main_sin_q, main_sin_d;
    logic [OUT_W-1:0] skid_cos_q, skid_cos_d, skid_sin_q, skid_sin_d;
    logic             s_tready_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign w_acc     = bus.s_tvalid & s_tready_q;
    assign w_rdy     = bus.m_tready;
    assign w_cnt_sum = {1'b0, cnt_q} + (CNT_W+1)'(w_nsat);

    // Main register is cleared on drain so outputs read zero while invalid.
    always_comb begin
        state_d    = state_q;
        main_cos_d = main_cos_q;
        main_sin_d = main_sin_q;
        skid_cos_d = skid_cos_q;
        skid_sin_d = skid_sin_q;
        case (state_q)
            ST_EMPTY: begin
                if (w_acc) begin
                    main_cos_d = w_cos;
                    main_sin_d = w_sin;
                    state_d    = ST_ONE;
                end
            end
            ST_ONE: begin
                if (w_acc && !w_rdy) begin
                    skid_cos_d = w_cos;
                    skid_sin_d = w_sin;
                    state_d    = ST_FULL;
                end else if (w_acc) begin
                    main_cos_d = w_cos;
                    main_sin_d = w_sin;
                end else if (w_rdy) begin
                    main_cos_d = '0;
                    main_sin_d = '0;
                    state_d    = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (w_rdy) begin
                    main_cos_d = skid_cos_q;
                    main_sin_d = skid_sin_q;
                    skid_cos_d = '0;
                    skid_sin_d = '0;
                    state_d    = ST_ONE;
                end
            end
            default: begin
                main_cos_d = '0;
                main_sin_d = '0;
                state_d    = ST_EMPTY;
            end
        endcase

        cnt_d = cnt_q;
        if (sat_clr_i) begin
            cnt_d = '0;
        end else if (w_acc) begin
            cnt_d = w_cnt_sum[CNT_W] ? {CNT_W{1'b1}} : w_cnt_sum[CNT_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_EMPTY;
            main_cos_q <= '0;
            main_sin_q <= '0;
            skid_cos_q <= '0;
            skid_sin_q <= '0;
            s_tready_q <= 1'b1;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            main_cos_q <= main_cos_d;
            main_sin_q <= main_sin_d;
            skid_cos_q <= skid_cos_d;
            skid_sin_q <= skid_sin_d;
            s_tready_q <= (state_d != ST_FULL);
            cnt_q      <= cnt_d;
        end
    end

    assign bus.s_tready = s_tready_q;
    assign bus.m_tvalid = (state_q != ST_EMPTY);
    assign bus.m_cos    = main_cos_q;
    assign bus.m_sin    = main_sin_q;
    assign sat_cnt_o    = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_nco_iq_unpack_mc.sv
// ============================================================================
// Module   : tb_nco_iq_unpack_mc
// Brief    : Self-checking bench for nco_iq_unpack_mc against a queue model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_nco_iq_unpack_mc;
    localparam int N_CH    = 2;
    localparam int LANE_W  = 32;
    localparam int O_WIDTH = 12;
    localparam int CNT_W   = 16;
    localparam int SH      = 4;
    localparam int OMAX    = 2047;
    localparam int CMAX    = 65535;

    typedef struct packed {
        logic [23:0] cos;
        logic [23:0] sin;
    } samp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  cfg_conj;
    logic        cfg_swap;
    logic        sat_clr;
    logic [15:0] sat_cnt;

    nco_iq_unpack_mc_if #(.N_CH(N_CH), .LANE_W(LANE_W), .O_WIDTH(O_WIDTH)) bus ();

    nco_iq_unpack_mc #(.N_CH(N_CH), .LANE_W(LANE_W), .O_WIDTH(O_WIDTH), .CNT_W(CNT_W)) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .cfg_conj_i (cfg_conj),
        .cfg_swap_i (cfg_swap),
        .sat_clr_i  (sat_clr),
        .sat_cnt_o  (sat_cnt)
    );

    initial forever #5 clk = ~clk;

    int    n_vec = 0;
    int    n_err = 0;
    samp_t exp_q[$];
    int    model_cnt = 0;

    logic        obs_valid, obs_rdy, exp_valid, exp_rdy;
    logic [23:0] obs_cos, obs_sin, exp_cos, exp_sin;
    logic [15:0] obs_cnt, exp_cnt;
    logic        last_acc;

    // Reference: floor((x + 2^(SH-1)) / 2^SH), clip high, negate sin, swap.
    function automatic void model(input logic [63:0] td, input logic [1:0] conj,
                                  input logic swap, output samp_t s, output int nsat);
        logic signed [15:0] v;
        int x, y;
        int r[2];
        s    = '0;
        nsat = 0;
        for (int k = 0; k < 2; k++) begin
            for (int c = 0; c < 2; c++) begin
                v = td[k*32 + c*16 +: 16];
                x = v;
                y = (x + (1 << (SH-1))) >>> SH;
                if (y > OMAX) begin y = OMAX; nsat++; end
                if (c == 1 && conj[k]) begin
                    y = -y;
                    if (y > OMAX) begin y = OMAX; nsat++; end
                end
                r[c] = y;
            end
            s.cos[k*12 +: 12] = 12'(swap ? r[1] : r[0]);
            s.sin[k*12 +: 12] = 12'(swap ? r[0] : r[1]);
        end
    endfunction

    function automatic logic [63:0] ramp_word(input int r);
        logic [63:0] w;
        w = '0;
        for (int k = 0; k < 2; k++) begin
            w[k*32 +: 16]      = 16'((r*4 + 2*k) << 4);
            w[k*32 + 16 +: 16] = 16'((r*4 + 2*k + 1) << 4);
        end
        return w;
    endfunction

    // Samples DUT and model at the negedge, then advances the model one clock.
    task automatic tick();
        samp_t ns;
        int    nsat;
        logic  acc, xfer;
        @(negedge clk);
        obs_valid = bus.m_tvalid;
        obs_rdy   = bus.s_tready;
        obs_cos   = bus.m_cos;
        obs_sin   = bus.m_sin;
        obs_cnt   = sat_cnt;
        exp_valid = (exp_q.size() > 0);
        exp_rdy   = (exp_q.size() < 2);
        exp_cos   = exp_valid ? exp_q[0].cos : '0;
        exp_sin   = exp_valid ? exp_q[0].sin : '0;
        exp_cnt   = 16'(model_cnt);
        last_acc  = 1'b0;
        if (!rst_n) begin
            exp_q.delete();
            model_cnt = 0;
        end else begin
            acc  = bus.s_tvalid && exp_rdy;
            xfer = exp_valid && bus.m_tready;
            if (xfer) void'(exp_q.pop_front());
            model(bus.s_tdata, cfg_conj, cfg_swap, ns, nsat);
            if (acc) exp_q.push_back(ns);
            if (sat_clr) model_cnt = 0;
            else if (acc) model_cnt = (model_cnt + nsat > CMAX) ? CMAX : model_cnt + nsat;
            last_acc = acc;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; bus.s_tvalid = 1'b1; bus.s_tdata = {$urandom, $urandom};
        bus.m_tready = 1'b1; cfg_conj = '0; cfg_swap = 1'b0; sat_clr = 1'b0;
        repeat (3) begin
            tick();
            n_vec++;
            if (obs_valid !== 1'b0 || obs_cos !== '0 || obs_sin !== '0 ||
                obs_rdy !== 1'b1 || obs_cnt !== '0) begin
                n_err++;
                $display("FAIL reset: got v=%0b cos=%h sin=%h rdy=%0b cnt=%h, want 0/0/0/1/0",
                         obs_valid, obs_cos, obs_sin, obs_rdy, obs_cnt);
            end
        end
        bus.s_tvalid = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        bus.s_tdata = {32'h0, 16'hFFF0, 16'h1234}; bus.s_tvalid = 1'b1; bus.m_tready = 1'b1;
        tick();
        bus.s_tvalid = 1'b0;
        tick();
        n_vec++;
        if (obs_valid !== 1'b1 || obs_cos[11:0] !== 12'h123 || obs_sin[11:0] !== 12'hFFF) begin
            n_err++;
            $display("FAIL basic: got v=%0b cos=%h sin=%h, want 1 123 FFF", obs_valid, obs_cos[11:0], obs_sin[11:0]);
        end
        tick();
        n_vec++;
        if (obs_valid !== 1'b0 || obs_cos !== '0 || obs_sin !== '0) begin
            n_err++;
            $display("FAIL zero_when_idle: got v=%0b cos=%h sin=%h, want 0 0 0", obs_valid, obs_cos, obs_sin);
        end
    endtask

    task automatic test_clip();
        sat_clr = 1'b1;
        tick();
        sat_clr = 1'b0;
        bus.s_tdata = {16'h8000, 16'h0000, 16'h0000, 16'h7FF8}; cfg_conj = 2'b10; bus.s_tvalid = 1'b1;
        tick();
        bus.s_tvalid = 1'b0; cfg_conj = 2'b00;
        tick();
        n_vec++;
        if (obs_cos[11:0] !== 12'h7FF || obs_sin[23:12] !== 12'h7FF || obs_cnt !== 16'd2) begin
            n_err++;
            $display("FAIL clip: got cos0=%h sin1=%h cnt=%0d, want 7FF 7FF 2", obs_cos[11:0], obs_sin[23:12], obs_cnt);
        end
        tick();
    endtask

    task automatic test_swap();
        bus.s_tdata = {32'h0, 16'h0200, 16'h0100}; cfg_swap = 1'b1; bus.s_tvalid = 1'b1;
        tick();
        bus.s_tvalid = 1'b0; cfg_swap = 1'b0;
        tick();
        n_vec++;
        if (obs_cos[11:0] !== 12'h020 || obs_sin[11:0] !== 12'h010) begin
            n_err++;
            $display("FAIL swap: got cos=%h sin=%h, want 020 010", obs_cos[11:0], obs_sin[11:0]);
        end
        tick();
    endtask

    task automatic test_backpressure();
        int   idx = 0, rcv = 0, cyc = 0;
        logic rdy_now;
        bus.s_tvalid = 1'b1;
        while (rcv < 100 && cyc < 3000) begin
            if (idx < 100) bus.s_tdata = ramp_word(idx);
            bus.s_tvalid = (idx < 100);
            rdy_now = ($urandom_range(0, 9) < 3);
            bus.m_tready = rdy_now;
            tick();
            cyc++;
            n_vec++;
            if (obs_valid !== exp_valid || obs_cos !== exp_cos || obs_sin !== exp_sin || obs_rdy !== exp_rdy) begin
                n_err++;
                $display("FAIL bp_stream: got v=%0b rdy=%0b cos=%h sin=%h, want v=%0b rdy=%0b cos=%h sin=%h",
                         obs_valid, obs_rdy, obs_cos, obs_sin, exp_valid, exp_rdy, exp_cos, exp_sin);
            end
            if (obs_valid && rdy_now) begin
                n_vec++;
                if (obs_cos[11:0] !== 12'(rcv*4) || obs_sin[23:12] !== 12'(rcv*4 + 3)) begin
                    n_err++;
                    $display("FAIL bp_order: got cos0=%h sin1=%h, want %h %h",
                             obs_cos[11:0], obs_sin[23:12], 12'(rcv*4), 12'(rcv*4 + 3));
                end
                rcv++;
            end
            if (last_acc) idx++;
        end
        n_vec++;
        if (rcv != 100) begin
            n_err++;
            $display("FAIL bp_count: got %0d samples, want 100", rcv);
        end
        bus.s_tvalid = 1'b0; bus.m_tready = 1'b1;
        tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            bus.s_tvalid = ($urandom_range(0, 9) < 7);
            bus.s_tdata  = {$urandom, $urandom};
            if ($urandom_range(0, 3) == 0) bus.s_tdata[15:0] = 16'h7FFF;
            if ($urandom_range(0, 3) == 0) bus.s_tdata[63:48] = 16'h8000;
            cfg_conj     = 2'($urandom);
            cfg_swap     = 1'($urandom);
            sat_clr      = ($urandom_range(0, 19) == 0);
            bus.m_tready = ($urandom_range(0, 9) < 6);
            tick();
            n_vec++;
            if (obs_valid !== exp_valid || obs_cos !== exp_cos || obs_sin !== exp_sin ||
                obs_rdy !== exp_rdy || obs_cnt !== exp_cnt) begin
                n_err++;
                $display("FAIL random: got v=%0b rdy=%0b cos=%h sin=%h cnt=%0d, want v=%0b rdy=%0b cos=%h sin=%h cnt=%0d",
                         obs_valid, obs_rdy, obs_cos, obs_sin, obs_cnt, exp_valid, exp_rdy, exp_cos, exp_sin, exp_cnt);
            end
        end
        bus.s_tvalid = 1'b0; bus.m_tready = 1'b1; sat_clr = 1'b0;
        repeat (3) tick();
    endtask

    task automatic test_counter();
        sat_clr = 1'b1; cfg_conj = '0; cfg_swap = 1'b0;
        tick();
        sat_clr = 1'b0;
        bus.s_tdata = 64'h7FFF7FFF_7FFF7FFF; bus.s_tvalid = 1'b1; bus.m_tready = 1'b1;
        repeat (16400) begin
            tick();
            n_vec++;
            if (obs_cnt !== exp_cnt) begin
                n_err++;
                $display("FAIL cnt_track: got %0d, want %0d", obs_cnt, exp_cnt);
            end
        end
        n_vec++;
        if (obs_cnt !== 16'hFFFF) begin
            n_err++;
            $display("FAIL cnt_hold: got %h, want FFFF", obs_cnt);
        end
        sat_clr = 1'b1;
        tick();
        sat_clr = 1'b0; bus.s_tvalid = 1'b0;
        tick();
        n_vec++;
        if (obs_cnt !== 16'h0000) begin
            n_err++;
            $display("FAIL cnt_clr_wins: got %h, want 0000", obs_cnt);
        end
        tick();
    endtask

    task automatic test_midreset();
        bus.s_tdata = ramp_word(5); bus.s_tvalid = 1'b1; bus.m_tready = 1'b0;
        repeat (3) tick();
        n_vec++;
        if (obs_rdy !== 1'b0 || obs_valid !== 1'b1) begin
            n_err++;
            $display("FAIL pre_reset_full: got rdy=%0b v=%0b, want 0 1", obs_rdy, obs_valid);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (bus.m_tvalid !== 1'b0 || bus.s_tready !== 1'b1 || bus.m_cos !== '0 ||
            bus.m_sin !== '0 || sat_cnt !== '0) begin
            n_err++;
            $display("FAIL async_reset: got v=%0b rdy=%0b cos=%h sin=%h cnt=%h, want 0 1 0 0 0",
                     bus.m_tvalid, bus.s_tready, bus.m_cos, bus.m_sin, sat_cnt);
        end
        tick();
        rst_n = 1'b1; bus.s_tvalid = 1'b0; bus.m_tready = 1'b1;
        tick();
        n_vec++;
        if (obs_rdy !== 1'b1 || obs_valid !== 1'b0) begin
            n_err++;
            $display("FAIL post_reset: got rdy=%0b v=%0b, want 1 0", obs_rdy, obs_valid);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_clip();
        test_swap();
        test_backpressure();
        test_random();
        test_counter();
        test_midreset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
